// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package seg7_pkg;

  typedef enum logic {
    StBlank,
    StShow
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry n is the pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed common-anode hex display scanner with per-digit blanking gap.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading-zero digits.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);
  localparam logic [CntW-1:0] CntInit = CntW'(BLANK_CYCLES);

  logic                s1_q, s2_q, s3_q;
  logic                tick;
  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic [3:0]          nibble;
  logic [6:0]          hex_seg;
  logic                lz_blank;

  // sclk is asynchronous data: three flops give a synchroniser plus edge history.
  assign tick   = s2_q & ~s3_q;
  assign nibble = val_q[4*idx_q +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (hex_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank = (idx_q != '0);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i >= int'(idx_q) && val_q[4*i +: 4] != 4'h0) lz_blank = 1'b0;
    end
    if (dp_q[idx_q]) lz_blank = 1'b0;
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    dp_d    = dp_q;
    if (tick) begin
      idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
      state_d = StBlank;
      cnt_d   = CntInit;
      // Snapshot only on wrap so a full scan never mixes old and new digits.
      if (idx_q == LastIdx) begin
        val_d = value;
        dp_d  = dp;
      end
    end else begin
      unique case (state_q)
        StBlank: begin
          if (cnt_q == '0) state_d = StShow;
          else             cnt_d   = cnt_q - CntW'(1);
        end
        StShow: ;
        default: state_d = StBlank;
      endcase
    end
  end

  always_comb begin
    an_d   = '1;
    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    if (state_q == StShow) begin
      seg_d = hex_seg;
      if (en) begin
        if (!lz_blank) an_d[idx_q] = 1'b0;
        dp_n_d = ~dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= StBlank;
      idx_q   <= '0;
      cnt_q   <= CntInit;
      val_q   <= '0;
      dp_q    <= '0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dp_n_q  <= 1'b1;
    end else begin
      s1_q    <= sclk;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_n_q  <= dp_n_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dp_n_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan (DIGITS=4, BLANK_CYCLES=4).
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        en = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int checks = 0;
  int errors = 0;

  seg7_scan #(
    .DIGITS       (4),
    .BLANK_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sclk  (sclk),
    .en    (en),
    .value (value),
    .dp    (dp),
    .an    (an),
    .seg   (seg),
    .dp_n  (dp_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dpn);
    check({tag, ".an"}, 32'(an), 32'(e_an));
    check({tag, ".seg"}, 32'(seg), 32'(e_seg));
    check({tag, ".dp_n"}, 32'(dp_n), 32'(e_dpn));
  endtask

  // One slow-clock period, then sample well after the new digit is shown.
  task automatic adv(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                     input logic e_dpn);
    @(posedge clk); #1 sclk = 1'b1;
    repeat (4) @(posedge clk);
    #1 sclk = 1'b0;
    repeat (8) @(posedge clk);
    #1 check_out(tag, e_an, e_seg, e_dpn);
  endtask

  initial begin
    // Reset hold with sclk toggling
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 sclk = ~sclk;
      check_out("rst_hold", 4'hF, 7'h7F, 1'b1);
      @(posedge clk);
    end
    #1 sclk = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 check_out("post_rst_digit0", 4'hE, 7'h40, 1'b1);

    // Walk to the wrap point; snapshot is still zero
    value = 16'h1234;
    adv("pre_d1", 4'hD, 7'h40, 1'b1);
    adv("pre_d2", 4'hB, 7'h40, 1'b1);
    adv("pre_d3", 4'h7, 7'h40, 1'b1);

    // Wrap: blank gap length, then digit 0 of the new snapshot
    @(posedge clk); #1 sclk = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("gap_still_blank", 32'(an), 32'hF);
    @(posedge clk);
    #1 check_out("gap_show_d0", 4'hE, 7'h19, 1'b1);
    repeat (3) @(posedge clk);
    #1 sclk = 1'b0;
    repeat (6) @(posedge clk);

    adv("scan_d1", 4'hD, 7'h30, 1'b1);
    adv("scan_d2", 4'hB, 7'h24, 1'b1);
    adv("scan_d3", 4'h7, 7'h79, 1'b1);
    adv("scan2_d0", 4'hE, 7'h19, 1'b1);
    adv("scan2_d1", 4'hD, 7'h30, 1'b1);
    adv("scan2_d2", 4'hB, 7'h24, 1'b1);
    adv("scan2_d3", 4'h7, 7'h79, 1'b1);

    // Snapshot: value change mid-scan must not tear the scan
    value = 16'hABCD;
    adv("snap_d0", 4'hE, 7'h21, 1'b1);
    adv("snap_d1", 4'hD, 7'h46, 1'b1);
    adv("snap_d2", 4'hB, 7'h03, 1'b1);
    value = 16'h0000;
    adv("snap_d3", 4'h7, 7'h08, 1'b1);
    adv("snap_new_d0", 4'hE, 7'h40, 1'b1);

    // Blank restart: two ticks two clocks apart
    @(posedge clk); #1 sclk = 1'b1;
    @(posedge clk); #1 sclk = 1'b0;
    @(posedge clk); #1 sclk = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("restart_blank", 32'(an), 32'hF);
    @(posedge clk);
    #1 check_out("restart_d2", 4'hB, 7'h40, 1'b1);
    #1 sclk = 1'b0;
    repeat (6) @(posedge clk);

    // Enable off for a scan; snapshot still updates
    en    = 1'b0;
    dp    = 4'b0100;
    value = 16'h1234;
    adv("en0_d3", 4'hF, 7'h40, 1'b1);
    adv("en0_d0", 4'hF, 7'h19, 1'b1);
    adv("en0_d1", 4'hF, 7'h30, 1'b1);
    adv("en0_d2", 4'hF, 7'h24, 1'b1);
    en = 1'b1;
    adv("dp_d3", 4'h7, 7'h79, 1'b1);
    adv("dp_d0", 4'hE, 7'h19, 1'b1);
    adv("dp_d1", 4'hD, 7'h30, 1'b1);
    adv("dp_d2", 4'hB, 7'h24, 1'b0);

    // Leading zeros
    dp    = 4'b0000;
    value = 16'h0050;
    adv("lz_d3_old", 4'h7, 7'h79, 1'b1);
    adv("lz_d0", 4'hE, 7'h40, 1'b1);
    adv("lz_d1", 4'hD, 7'h12, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    adv("lz_d2", 4'hF, 7'h40, 1'b1);
    adv("lz_d3", 4'hF, 7'h40, 1'b1);
`else
    adv("lz_d2", 4'hB, 7'h40, 1'b1);
    adv("lz_d3", 4'h7, 7'h40, 1'b1);
`endif

    // Reset mid-scan aborts immediately and clears the snapshot
    value = 16'h1234;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    #1 check_out("mid_rst", 4'hF, 7'h7F, 1'b1);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 check_out("mid_rst_recover", 4'hE, 7'h40, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
